// File: rtl/mdu_div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Latency: 34 cycles from START to DONE normally; 1 cycle for divide-by-zero and signed overflow.
// Backpressure: none; BUSY stalls the issuing stage, START while busy is ignored, FLUSH aborts.
module mdu_div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  func,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [4:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic        neg_q;
    logic        neg_r;
    logic        rem_op;

    // operand decode at issue
    logic        is_signed;
    logic        is_rem;
    logic        div_zero;
    logic        div_ovf;
    logic        special;
    logic [31:0] special_res;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    // one restoring step
    logic [32:0] rem_sh;
    logic [33:0] diff;
    logic        no_borrow;
    logic [32:0] rem_step;
    logic [31:0] quo_step;

    // sign fix-up
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] fix_res;

    assign busy = (state == CALC) || (state == FIX);

    // decode operation and detect the single-cycle cases
    always_comb begin
        is_signed   = ~func[0];
        is_rem      = func[1];
        div_zero    = (op_b == 32'd0);
        div_ovf     = is_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
        special     = div_zero || div_ovf;
        special_res = 32'd0;
        if (div_zero) begin
            special_res = is_rem ? op_a : 32'hFFFF_FFFF;
        end else begin
            special_res = is_rem ? 32'd0 : 32'h8000_0000;
        end
        // negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude
        mag_a = (is_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
        mag_b = (is_signed && op_b[31]) ? (32'd0 - op_b) : op_b;
    end

    // restoring step: shift in next dividend bit, subtract divisor when it fits
    always_comb begin
        rem_sh    = {rem[31:0], quo[31]};
        diff      = {1'b0, rem_sh} - {2'b00, divisor};
        // rem[32] set means the shifted value is at least 2^33, so the subtract always fits
        no_borrow = rem[32] | ~diff[33];
        rem_step  = no_borrow ? diff[32:0] : rem_sh;
        quo_step  = {quo[30:0], no_borrow};
    end

    // sign correction applied in FIX
    always_comb begin
        q_fix   = neg_q ? (32'd0 - quo) : quo;
        r_fix   = neg_r ? (32'd0 - rem[31:0]) : rem[31:0];
        fix_res = rem_op ? r_fix : q_fix;
    end

    // next-state logic; flush always returns to IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start && !special) state_nxt = CALC;
            CALC: if (cnt == 5'd0) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt = IDLE;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // datapath: operand latch, iteration, result write and done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= 5'd0;
            rem     <= 33'd0;
            quo     <= 32'd0;
            divisor <= 32'd0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            rem_op  <= 1'b0;
            done    <= 1'b0;
            result  <= 32'd0;
        end else begin
            done <= 1'b0;
            if (!flush) begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            if (special) begin
                                result <= special_res;
                                done   <= 1'b1;
                            end else begin
                                rem     <= 33'd0;
                                quo     <= mag_a;
                                divisor <= mag_b;
                                neg_q   <= is_signed && (op_a[31] ^ op_b[31]);
                                neg_r   <= is_signed && op_a[31];
                                rem_op  <= is_rem;
                                cnt     <= 5'd31;
                            end
                        end
                    end
                    CALC: begin
                        rem <= rem_step;
                        quo <= quo_step;
                        if (cnt != 5'd0) begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                    FIX: begin
                        result <= fix_res;
                        done   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mdu_div_iter.sv
module tb_mdu_div_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  func;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] F_DIV  = 2'b00;
    localparam logic [1:0] F_DIVU = 2'b01;
    localparam logic [1:0] F_REM  = 2'b10;
    localparam logic [1:0] F_REMU = 2'b11;

    mdu_div_iter dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .func   (func),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // advance one edge and sample shortly after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // issue one op with a single-cycle START; report edges after the start edge until DONE
    // and how many sampled cycles had BUSY high (bounded at 60 edges)
    task automatic run_op(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        func  = f;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        bcnt  = 0;
        while (!done && lat < 60) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int lat, bcnt;
        run_op(F_DIVU, 32'd100, 32'd7, lat, bcnt);
        checks++;
        if (lat !== 33) begin errors++; $display("FAIL divu_latency: got %0d expected 33", lat); end
        checks++;
        if (bcnt !== 33) begin errors++; $display("FAIL divu_busy_cycles: got %0d expected 33", bcnt); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL divu_busy_in_done: got %b expected 0", busy); end
        checks++;
        if (result !== 32'd14) begin errors++; $display("FAIL divu_100_7: got %h expected 0000000e", result); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL divu_done_pulse: got %b expected 0", done); end
        checks++;
        if (result !== 32'd14) begin errors++; $display("FAIL divu_result_hold: got %h expected 0000000e", result); end
        run_op(F_REMU, 32'd100, 32'd7, lat, bcnt);
        checks++;
        if (result !== 32'd2 || lat !== 33) begin
            errors++; $display("FAIL remu_100_7: got %h lat %0d expected 00000002 lat 33", result, lat);
        end
        tick();
    endtask

    task automatic test_signed();
        int lat, bcnt;
        run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        checks++;
        if (result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_m7_2: got %h expected fffffffd", result); end
        tick();
        run_op(F_REM, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        checks++;
        if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_m7_2: got %h expected ffffffff", result); end
        tick();
        run_op(F_DIV, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
        checks++;
        if (result !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_7_m2: got %h expected fffffffd", result); end
        tick();
        run_op(F_REM, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
        checks++;
        if (result !== 32'd1) begin errors++; $display("FAIL rem_7_m2: got %h expected 00000001", result); end
        tick();
        run_op(F_DIV, 32'h8000_0000, 32'd2, lat, bcnt);
        checks++;
        if (result !== 32'hC000_0000 || lat !== 33) begin
            errors++; $display("FAIL div_min_2: got %h lat %0d expected c0000000 lat 33", result, lat);
        end
        tick();
        run_op(F_DIVU, 32'hFFFF_FFFF, 32'd16, lat, bcnt);
        checks++;
        if (result !== 32'h0FFF_FFFF) begin errors++; $display("FAIL divu_max_16: got %h expected 0fffffff", result); end
        tick();
    endtask

    task automatic test_special();
        int lat, bcnt;
        run_op(F_DIVU, 32'd5, 32'd0, lat, bcnt);
        checks++;
        if (lat !== 0 || bcnt !== 0) begin
            errors++; $display("FAIL divu_by0_latency: got lat %0d busy %0d expected lat 0 busy 0", lat, bcnt);
        end
        checks++;
        if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_by0: got %h expected ffffffff", result); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL by0_busy: got %b expected 0", busy); end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL by0_done_pulse: got %b expected 0", done); end
        run_op(F_REM, 32'd5, 32'd0, lat, bcnt);
        checks++;
        if (result !== 32'd5 || lat !== 0) begin
            errors++; $display("FAIL rem_by0: got %h lat %0d expected 00000005 lat 0", result, lat);
        end
        tick();
        run_op(F_DIV, 32'd5, 32'd0, lat, bcnt);
        checks++;
        if (result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_by0: got %h expected ffffffff", result); end
        tick();
        run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        checks++;
        if (result !== 32'h8000_0000 || lat !== 0) begin
            errors++; $display("FAIL div_ovf: got %h lat %0d expected 80000000 lat 0", result, lat);
        end
        tick();
        run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        checks++;
        if (result !== 32'h0 || lat !== 0) begin
            errors++; $display("FAIL rem_ovf: got %h lat %0d expected 00000000 lat 0", result, lat);
        end
        tick();
    endtask

    task automatic test_flush();
        int lat, bcnt, seen;
        logic [31:0] prev;
        prev  = result;
        func  = F_DIVU;
        op_a  = 32'd100;
        op_b  = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        start = 1'b1;
        tick();
        flush = 1'b0;
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL flush_state: got busy %b done %b expected 0 0", busy, done);
        end
        checks++;
        if (result !== prev) begin errors++; $display("FAIL flush_result: got %h expected %h", result, prev); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses expected 0", seen); end
        run_op(F_DIVU, 32'd9, 32'd3, lat, bcnt);
        checks++;
        if (result !== 32'd3 || lat !== 33) begin
            errors++; $display("FAIL after_flush_9_3: got %h lat %0d expected 00000003 lat 33", result, lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        func  = F_DIVU;
        op_a  = 32'd100;
        op_b  = 32'd7;
        start = 1'b1;
        tick();
        // operands for the next op are presented while busy and must not disturb this one
        op_a = 32'd9;
        op_b = 32'd3;
        lat1 = 0;
        while (!done && lat1 < 60) begin
            tick();
            lat1++;
        end
        checks++;
        if (result !== 32'd14 || lat1 !== 33) begin
            errors++; $display("FAIL b2b_first: got %h lat %0d expected 0000000e lat 33", result, lat1);
        end
        tick();
        lat2 = 1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_reissue: got busy %b done %b expected 1 0", busy, done);
        end
        while (!done && lat2 < 60) begin
            tick();
            lat2++;
        end
        checks++;
        if (result !== 32'd3 || lat2 !== 34) begin
            errors++; $display("FAIL b2b_second: got %h spacing %0d expected 00000003 spacing 34", result, lat2);
        end
        start = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        func  = F_DIVU;
        op_a  = 32'd100;
        op_b  = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        reset = 1'b1;
        start = 1'b1;
        flush = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            errors++; $display("FAIL reset_mid: got busy %b done %b result %h expected 0 0 00000000", busy, done, result);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) seen++;
            tick();
        end
        checks++;
        if (seen !== 0 || result !== 32'h0) begin
            errors++; $display("FAIL reset_mid_no_done: got %0d pulses result %h expected 0 00000000", seen, result);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        func  = 2'b00;
        op_a  = 32'd0;
        op_b  = 32'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
